div_result_bcd: RTL

DIV_RESULT_BCD -- requirements
Module: div_result_bcd

---
 rtl/div_result_bcd_pkg.sv | 15 +
 rtl/div_result_bcd_bcd_add3.sv | 10 +
 rtl/div_result_bcd.sv | 125 ++++++++++++
 3 files changed

// File: rtl/div_result_bcd_pkg.sv
// Shared constants and FSM encoding for the divider-result BCD converter.
package div_result_bcd_pkg;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_result_bcd_bcd_add3.sv
// Combinational double-dabble cell: a BCD digit of 5 or more gets 3 added
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= 4'd5) ? (d_in + 4'd3) : d_in;

endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider's quotient and remainder to packed BCD in parallel using
// sequential double dabble, with a valid/ready handshake on both sides.
module div_result_bcd
  import div_result_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] remainder,
  input  logic             div_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] q_bcd,
  output logic [BCD_W-1:0] r_bcd,
  output logic             err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_op_q, q_op_d, r_op_q, r_op_d;
  logic [BCD_W-1:0]   q_acc_q, q_acc_d, r_acc_q, r_acc_d;
  logic               err_acc_q, err_acc_d;
  logic [BCD_W-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]       q_adj, r_adj;
  logic [BCD_W+WIDTH-1:0] q_shift, r_shift;
  logic                   last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_q_add3 (.d_in(q_acc_q[4*g +: 4]), .d_out(q_adj[4*g +: 4]));
    bcd_add3 u_r_add3 (.d_in(r_acc_q[4*g +: 4]), .d_out(r_adj[4*g +: 4]));
  end

  assign q_shift    = {q_adj, q_op_q} << 1;
  assign r_shift    = {r_adj, r_op_q} << 1;
  assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      q_op_q    <= '0;
      r_op_q    <= '0;
      q_acc_q   <= '0;
      r_acc_q   <= '0;
      err_acc_q <= 1'b0;
      q_bcd_q   <= '0;
      r_bcd_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_op_q    <= q_op_d;
      r_op_q    <= r_op_d;
      q_acc_q   <= q_acc_d;
      r_acc_q   <= r_acc_d;
      err_acc_q <= err_acc_d;
      q_bcd_q   <= q_bcd_d;
      r_bcd_q   <= r_bcd_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_CONV;
      ST_CONV: if (last_shift) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Presented outputs are only reloaded on the final shift, so they keep the
  // previous result while a new conversion is in flight.
  always_comb begin
    cnt_d     = cnt_q;
    q_op_d    = q_op_q;
    r_op_d    = r_op_q;
    q_acc_d   = q_acc_q;
    r_acc_d   = r_acc_q;
    err_acc_d = err_acc_q;
    q_bcd_d   = q_bcd_q;
    r_bcd_d   = r_bcd_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          q_op_d    = quotient;
          r_op_d    = remainder;
          err_acc_d = div_zero;
          q_acc_d   = '0;
          r_acc_d   = '0;
          cnt_d     = '0;
        end
      end
      ST_CONV: begin
        q_acc_d = q_shift[BCD_W+WIDTH-1:WIDTH];
        q_op_d  = q_shift[WIDTH-1:0];
        r_acc_d = r_shift[BCD_W+WIDTH-1:WIDTH];
        r_op_d  = r_shift[WIDTH-1:0];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_shift) begin
          q_bcd_d = q_shift[BCD_W+WIDTH-1:WIDTH];
          r_bcd_d = r_shift[BCD_W+WIDTH-1:WIDTH];
          err_d   = err_acc_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign q_bcd = q_bcd_q;
  assign r_bcd = r_bcd_q;
  assign err   = err_q;

endmodule
